ins_mem_ctrl: RTL
=================

INS_MEM_CTRL -- requirements
Module: ins_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DEPTH, default 10000, memory size in bytes.
REQ-003 SHALL have parameter LATENCY, default 1, fetch latency in cycles; legal range 1..4.
REQ-004 SHALL have parameter BASE, default 0, byte address of memory byte 0.
REQ-005 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port IReq  input  1  fetch request.
REQ-008 SHALL have port IAddr  input  ADDR_W  fetch byte address.
REQ-009 SHALL have port IReady  output  1  fetch request can be accepted.
REQ-010 SHALL have port IValid  output  1  IDataOut/IErr are valid.
REQ-011 SHALL have port IAck  input  1  consumer accepts the response.
REQ-012 SHALL have port IDataOut  output  32  fetched instruction word.
REQ-013 SHALL have port IErr  output  1  fetch fault (misaligned or out of range).
REQ-014 SHALL have port LdEn  input  1  byte-load strobe (present only with IMEM_LOAD_EN).
REQ-015 SHALL have port LdAddr  input  ADDR_W  byte-load address (present only with IMEM_LOAD_EN).
REQ-016 SHALL have port LdData  input  8  byte-load data (present only with IMEM_LOAD_EN).

Function
REQ-017 SHALL store DEPTH bytes; word at A = {mem[A-BASE+3], mem[A-BASE+2], mem[A-BASE+1], mem[A-BASE]} (little-endian).
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: IReady=1; IReq=1 accepts; LATENCY=1 goes to RESP, otherwise to WAIT with counter = LATENCY-1.
- WAIT: counter decrements each cycle; at 1 it goes to RESP.
REQ-019 SHALL read the word on the accept cycle; a same-cycle load to those bytes SHALL NOT be visible to that fetch (read-before-write).
REQ-020 SHALL assert IValid in RESP only, holding IDataOut/IErr stable until IAck=1; IAck with IValid returns to IDLE next cycle.
REQ-021 SHALL keep IReady=0 in WAIT and RESP; IReq there is ignored, not queued.
REQ-022 SHALL give accept-to-IValid latency of exactly LATENCY cycles.
REQ-023 SHALL flag IErr=1, IDataOut=0 when IAddr[1:0]!=0 or IAddr<BASE or IAddr-BASE+3>=DEPTH; the faulting fetch still completes the handshake.
REQ-024 SHALL compute address arithmetic in ADDR_W bits; wrap below BASE counts as out of range.
REQ-025 SHALL drive IDataOut=0 and IErr=0 whenever IValid=0.

Reset
REQ-026 SHALL, on RST=0, immediately force IDLE, IReady=1, IValid=0, IErr=0, IDataOut=0, counter=0.
REQ-027 SHALL abort any in-flight fetch on reset mid-operation with no response issued; memory contents SHALL be retained.
REQ-028 SHALL ignore LdEn while RST=0.

Configuration
REQ-029 SHALL, with IMEM_LOAD_EN defined, provide LdEn/LdAddr/LdData: LdEn=1 writes LdData to mem[LdAddr-BASE] on the clock edge; out-of-range writes are dropped; loads proceed in any FSM state.
REQ-030 SHALL, without IMEM_LOAD_EN, omit the load ports; contents come only from simulation initialisation; the memory is read-only.

Verification
REQ-031 SHALL cover: LATENCY=1, load bytes 0x40,0x00,0x00,0xE0 at BASE..BASE+3, fetch BASE -> IValid 1 cycle after accept, IDataOut=0xE0000040, IErr=0.
REQ-032 SHALL cover: LATENCY=3, fetch BASE+8 with IAck held 0 for 5 cycles -> IValid 3 cycles after accept; data stable until IAck; IReady=0 throughout.
REQ-033 SHALL cover: fetch BASE+2 -> IErr=1, IDataOut=0; fetch BASE+DEPTH-2 -> IErr=1; fetch BASE+DEPTH-4 -> IErr=0.
REQ-034 SHALL cover: same-cycle accept of BASE+12 and load of 0xFF to BASE+12 -> old word returned; refetch -> low byte 0xFF.
REQ-035 SHALL cover: RST low during WAIT (LATENCY=4) -> IValid never asserts; IReady=1 immediately; post-reset fetch returns pre-reset contents.

Source files
------------

// File: rtl/ins_mem_ctrl.sv
// Byte-addressed instruction memory with a request/response fetch handshake.
// Optional byte-load port enabled by defining IMEM_LOAD_EN; default build is read-only.
module ins_mem_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter int                DEPTH   = 10000,
  parameter int                LATENCY = 1,
  parameter logic [ADDR_W-1:0] BASE    = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IReady,
  output logic              IValid,
  input  logic              IAck,
  output logic [31:0]       IDataOut,
  output logic              IErr
`ifdef IMEM_LOAD_EN
  ,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [7:0]        LdData
`endif
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(DEPTH - 4);
  localparam logic [1:0]        CNT_INIT = 2'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] data_q;
  logic        err_q;
  logic [7:0]  mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] f_off;
  logic [IDX_W-1:0]  f_idx;
  logic              f_err;
  logic [31:0]       f_word;

  // The last valid word starts at DEPTH-4, which avoids the +3 overflow of the end check.
  assign f_off  = IAddr - BASE;
  assign f_idx  = f_off[IDX_W-1:0];
  assign f_err  = (IAddr[1:0] != 2'b00) || (IAddr < BASE) || (f_off > LAST_OFF);
  assign f_word = {mem_q[f_idx + IDX_W'(3)], mem_q[f_idx + IDX_W'(2)],
                   mem_q[f_idx + IDX_W'(1)], mem_q[f_idx]};
  assign accept = (state_q == S_IDLE) && IReq;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response is captured on the accept edge, so a same-edge load cannot reach it.
  always_ff @(posedge CLK) begin
    if (accept) begin
      data_q <= f_err ? 32'h0 : f_word;
      err_q  <= f_err;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (IReq) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 2'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (IAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IReady   = (state_q == S_IDLE);
    IValid   = (state_q == S_RESP);
    IDataOut = IValid ? data_q : 32'h0;
    IErr     = IValid && err_q;
  end

`ifdef IMEM_LOAD_EN
  logic [ADDR_W-1:0] ld_off;
  logic              ld_ok;

  assign ld_off = LdAddr - BASE;
  assign ld_ok  = (LdAddr >= BASE) && (ld_off < ADDR_W'(DEPTH));

  // Loads are gated by RST so a strobe held during reset leaves memory untouched.
  always_ff @(posedge CLK) begin
    if (RST && LdEn && ld_ok) mem_q[ld_off[IDX_W-1:0]] <= LdData;
  end
`endif

endmodule
